// File: rtl/uart_pkg.sv
// Shared UART definitions for the byte transmitter and the future receiver.
// UART_TX_PARITY_EN adds an even-parity state and helper between DATA and STOP.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter that ticks on terminal count and reloads itself.
// restart holds the counter at its reload value so the next bit starts a full period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || tick) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// Outputs are registered from next-state values so command never reaches tx/has_done combinationally.
//
//   state  | meaning
//   IDLE   | line high, has_done high, waiting for command
//   START  | start bit (tx=0)
//   DATA   | eight latched data bits, LSB first
//   PARITY | even parity of the latched byte (parity build only)
//   STOP   | stop bit (tx=1), then back to IDLE
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      command,
    output logic                      has_done,
    output logic                      tx
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t               state_q, state_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      tx_q, tx_d;
    logic                      has_done_q, has_done_d;
    logic                      tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
            has_done_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            has_done_q <= has_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (command) begin
                    data_d    = data_in;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so each bit appears the edge its state starts.
    always_comb begin
        tx_d       = 1'b1;
        has_done_d = 1'b0;
        case (state_d)
            IDLE:   has_done_d = 1'b1;
            START:  tx_d = 1'b0;
            DATA:   tx_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = even_parity(data_d);
`endif
            STOP:   tx_d = 1'b1;
            default: begin
                tx_d       = 1'b1;
                has_done_d = 1'b1;
            end
        endcase
    end

    assign tx       = tx_q;
    assign has_done = has_done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: stimulus queues expected frames, a monitor decodes the line.
// Also measures bit widths on a second instance left at the default divider.
module tb_uart_byte_tx;

    localparam int N  = 4;
    localparam int NS = 434;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       command;
    logic [7:0] data_in;
    logic       has_done;
    logic       tx;
    logic       cmd_s;
    logic [7:0] din_s;
    logic       has_done_s;
    logic       tx_s;

    int n_vec       = 0;
    int n_err       = 0;
    int frames_seen = 0;
    int frames_exp  = 0;

    logic [FB-1:0] sb_q[$];
    logic [7:0]    hs_bytes [4] = '{8'h01, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    uart_byte_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .command  (command),
        .has_done (has_done),
        .tx       (tx)
    );

    uart_byte_tx dut_slow (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (din_s),
        .command  (cmd_s),
        .has_done (has_done_s),
        .tx       (tx_s)
    );

    // Time-ordered frame: bit 0 is the start bit.
    function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit expect_frame);
        data_in = b;
        command = 1'b1;
        if (expect_frame) begin
            sb_q.push_back(frame_of(b));
            frames_exp++;
        end
        @(negedge clk);
        command = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input string name);
        int t = 0;
        while (has_done !== lvl && t < FB * N * 2 + 10) begin
            @(negedge clk);
            t++;
        end
        if (has_done !== lvl) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: has_done=%b after %0d cycles, expected %b", name, has_done, t, lvl);
        end
    endtask

    task automatic wait_idle(input string name);
        wait_level(1'b1, name);
        check(name, 32'(has_done), 1);
    endtask

    initial begin : monitor
        logic [FB-1:0] act;
        logic [FB-1:0] exp_f;
        logic          v;
        logic          hd_end;
        bit            aborted;
        bit            stable;
        bit            hd_low;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                stable  = 1'b1;
                hd_low  = 1'b1;
                act     = '0;
                v       = 1'b0;
                for (int b = 0; b < FB && !aborted; b++) begin
                    for (int s = 0; s < N && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            if (s == 0) v = tx;
                            else if (tx !== v) stable = 1'b0;
                            if (has_done !== 1'b0) hd_low = 1'b0;
                        end
                    end
                    act[b] = v;
                end
                if (!aborted) begin
                    @(negedge clk);
                    hd_end = has_done;
                    frames_seen++;
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got frame %h, expected none", act);
                    end else begin
                        exp_f = sb_q.pop_front();
                        check("frame_bits", 32'(act), 32'(exp_f));
                        check("bit_width_stable", 32'(stable), 1);
                        check("done_window", 32'({hd_low, hd_end}), 3);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [FB-1:0] fs;
        int            runs[$];
        int            r;
        int            falls;
        int            t;
        int            last;
        int            idx;
        logic          prev;

        rst_n   = 1'b1;
        command = 1'b0;
        data_in = 8'h00;
        cmd_s   = 1'b0;
        din_s   = 8'h00;

        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", 32'(tx), 1);
        check("reset_has_done", 32'(has_done), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tx", 32'(tx), 1);
        check("idle_has_done", 32'(has_done), 1);

        send(8'hA5, 1'b1);
        wait_idle("single_a5");

        // Upstream holds command until has_done falls; data advances while the frame is in flight.
        data_in = hs_bytes[0];
        command = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(frame_of(hs_bytes[i]));
            frames_exp++;
        end
        falls = 0;
        for (int i = 0; i < 4; i++) begin
            wait_level(1'b0, "hs_fall");
            if (has_done === 1'b0) falls++;
            if (i < 3) begin
                data_in = hs_bytes[i+1];
                wait_level(1'b1, "hs_rise");
            end
        end
        command = 1'b0;
        wait_idle("hs_idle");
        check("hs_falls", 32'(falls), 4);

        send(8'hFF, 1'b0);
        repeat (4 * N + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_has_done", 32'(has_done), 1);
        check("midreset_tx", 32'(tx), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx", 32'(tx), 1);
        check("post_reset_has_done", 32'(has_done), 1);
        send(8'h3C, 1'b1);
        wait_idle("after_reset_3c");

        send(8'h5A, 1'b1);
        repeat (8) @(negedge clk);
        data_in = 8'h00;
        command = 1'b1;
        @(negedge clk);
        command = 1'b0;
        wait_idle("ignored_5a");
        repeat (3 * FB * N) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1);
        wait_idle("parity_07");
        send(8'h03, 1'b1);
        wait_idle("parity_03");
`endif

        // Default divider: time each run between line transitions.
        fs = frame_of(8'h55);
        r  = 1;
        for (int i = 1; i < FB; i++) begin
            if (fs[i] == fs[i-1]) begin
                r++;
            end else begin
                runs.push_back(r);
                r = 1;
            end
        end
        runs.push_back(r);
        din_s = 8'h55;
        cmd_s = 1'b1;
        @(negedge clk);
        cmd_s = 1'b0;
        t = 0;
        while (tx_s !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("slow_start", 32'(tx_s), 0);
        t    = 0;
        last = 0;
        idx  = 0;
        prev = 1'b0;
        while (t < FB * NS + 10) begin
            @(negedge clk);
            t++;
            if (tx_s !== prev) begin
                if (idx < runs.size()) begin
                    check("slow_bit_width", 32'(t - last), 32'(runs[idx] * NS));
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL slow_extra_edge: got edge at cycle %0d, expected none", t);
                end
                idx++;
                last = t;
                prev = tx_s;
            end
            if (has_done_s === 1'b1) break;
        end
        check("slow_frame_len", 32'(t), 32'(FB * NS));
        check("slow_edges", 32'(idx), 32'(runs.size() - 1));

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 0);
        check("frame_count", 32'(frames_seen), 32'(frames_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
